id_ex_skid_stage: RTL and testbench

- Parametrised ID/EX pipeline stage register for the pipelined datapath, sitting between decode (register file read, sign extension) and execute.
- Generalises the plain clocked ID/EX latch with a valid/ready handshake, a 2-entry skid buffer for backpressure (execute-side stall), and synchronous flush for branch/hazard squash.
- Outputs bubble-gated control fields and keeps a saturating count of bubbles delivered to execute.

---
 rtl/id_ex_skid_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_skid_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Latency: one cycle from an accepted input to out_valid; control outputs are bubble-gated.
// Backpressure: a stall parks one extra entry in skid; in_ready comes from the registered skid valid bit.
module id_ex_skid_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int WB_W   = 2,
    parameter int M_W    = 3,
    parameter int EX_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_rd1,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [M_W-1:0]    in_m,
    input  logic [EX_W-1:0]   in_ex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc4,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [WB_W-1:0]   out_wb,
    output logic [M_W-1:0]    out_m,
    output logic [EX_W-1:0]   out_ex,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] pc4;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [EX_W-1:0]   ex;
    } payload_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    payload_t in_dat;
    payload_t main_dat;
    payload_t skid_dat;
    logic     main_vld;
    logic     skid_vld;
    logic     accept;
    logic     drain;

    assign in_dat = '{pc4: in_pc4, rd1: in_rd1, rd2: in_rd2, imm: in_imm,
                      rt: in_rt, rd: in_rd, wb: in_wb, m: in_m, ex: in_ex};

    // Skid valid is a flop, so in_ready never depends combinationally on out_ready.
    assign in_ready = ~skid_vld;
    assign accept   = in_valid & ~skid_vld;
    assign drain    = main_vld & out_ready;

    // Main/skid entry update: flush squashes both, otherwise strict FIFO through main then skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_dat <= '0;
            skid_dat <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            // Data stays put; only the valid bits drop, control outputs gate to zero.
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld) begin
            // Skid is never occupied while main is empty.
            if (accept) begin
                main_dat <= in_dat;
                main_vld <= 1'b1;
            end
        end else if (drain) begin
            if (skid_vld) begin
                main_dat <= skid_dat;
                skid_vld <= 1'b0;
            end else if (accept) begin
                main_dat <= in_dat;
            end else begin
                main_vld <= 1'b0;
            end
        end else if (!skid_vld && accept) begin
            skid_dat <= in_dat;
            skid_vld <= 1'b1;
        end
    end

    // Count cycles where execute was ready but received a bubble; saturates, survives flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!main_vld && out_ready && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    assign out_valid = main_vld;
    assign out_pc4   = main_dat.pc4;
    assign out_rd1   = main_dat.rd1;
    assign out_rd2   = main_dat.rd2;
    assign out_imm   = main_dat.imm;
    assign out_rt    = main_dat.rt;
    assign out_rd    = main_dat.rd;
    assign out_wb    = main_dat.wb & {WB_W{main_vld}};
    assign out_m     = main_dat.m  & {M_W{main_vld}};
    assign out_ex    = main_dat.ex & {EX_W{main_vld}};

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: directed vectors with a scoreboard queue.
// Accepted inputs are queued by an input monitor; an output monitor pops on every drain.
// Directed checks cover reset, streaming, backpressure, flush, async reset and bubble count.
module tb_id_ex_skid_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int WW = 2;
    localparam int MW = 3;
    localparam int EW = 5;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_pc4, in_rd1, in_rd2, in_imm;
    logic [RW-1:0] in_rt, in_rd;
    logic [WW-1:0] in_wb;
    logic [MW-1:0] in_m;
    logic [EW-1:0] in_ex;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_pc4, out_rd1, out_rd2, out_imm;
    logic [RW-1:0] out_rt, out_rd;
    logic [WW-1:0] out_wb;
    logic [MW-1:0] out_m;
    logic [EW-1:0] out_ex;
    logic [CW-1:0] bubble_cnt;

    typedef struct packed {
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [WW-1:0] wb;
        logic [MW-1:0] m;
        logic [EW-1:0] ex;
    } pl_t;

    pl_t exp_q[$];
    pl_t exp_e;
    int  n_checks = 0;
    int  n_fail   = 0;

    id_ex_skid_stage #(
        .DATA_W(DW), .REG_W(RW), .WB_W(WW), .M_W(MW), .EX_W(EW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
        .in_rt(in_rt), .in_rd(in_rd), .in_wb(in_wb), .in_m(in_m), .in_ex(in_ex),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc4(out_pc4), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_rt(out_rt), .out_rd(out_rd), .out_wb(out_wb), .out_m(out_m), .out_ex(out_ex),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Payload fields are derived from pc4 so every vector is distinct and control is non-zero.
    task automatic set_in(input logic v, input logic [DW-1:0] pc);
        in_valid = v;
        in_pc4   = pc;
        in_rd1   = pc + 32'h1000_0000;
        in_rd2   = ~pc;
        in_imm   = {16'hFFFF, pc[15:0]};
        in_rt    = pc[6:2];
        in_rd    = pc[6:2] ^ 5'h1F;
        in_wb    = pc[3:2] | 2'b01;
        in_m     = pc[4:2] | 3'b100;
        in_ex    = pc[6:2] | 5'h10;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Input monitor: record every accepted transaction; flush and reset discard held entries.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(pl_t'({in_pc4, in_rd1, in_rd2, in_imm, in_rt, in_rd, in_wb, in_m, in_ex}));
        end
    end

    // Output monitor: every drain must match the oldest outstanding accepted transaction.
    always @(negedge clk) begin
        if (rst_n && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc4 %h, expected no output", out_pc4);
            end else begin
                exp_e = exp_q.pop_front();
                chk("sb_payload",
                    160'({out_pc4, out_rd1, out_rd2, out_imm, out_rt, out_rd, out_wb, out_m, out_ex}),
                    160'(exp_e));
            end
        end
    end

    logic [DW-1:0] stream_v [3];
    logic [CW-1:0] cnt_v    [5];

    initial begin
        stream_v = '{32'h10, 32'h14, 32'h18};
        cnt_v    = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        clk       = 1'b0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b1, 32'h4);

        // Reset holds everything cleared even with a valid input presented.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_in_ready", 160'(in_ready), 160'(1));
        chk("rst_bubble_cnt", 160'(bubble_cnt), 160'(0));
        chk("rst_out_fields",
            160'({out_pc4, out_rd1, out_rd2, out_imm, out_rt, out_rd, out_wb, out_m, out_ex}), 160'(0));
        rst_n = 1'b1;
        tick;
        chk("rel_out_valid", 160'(out_valid), 160'(1));
        chk("rel_out_pc4", 160'(out_pc4), 160'(32'h4));
        set_in(1'b0, 32'h0);

        // Streaming with execute always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, stream_v[i]);
            chk("stream_in_ready", 160'(in_ready), 160'(1));
            tick;
            chk("stream_out_valid", 160'(out_valid), 160'(1));
            chk("stream_out_pc4", 160'(out_pc4), 160'(stream_v[i]));
        end

        // Backpressure fills the skid entry, then drains in order.
        set_in(1'b1, 32'h20);
        tick;
        chk("bp_main_20", 160'(out_pc4), 160'(32'h20));
        out_ready = 1'b0;
        set_in(1'b1, 32'h24);
        tick;
        chk("bp_in_ready_low", 160'(in_ready), 160'(0));
        chk("bp_hold_20", 160'(out_pc4), 160'(32'h20));
        set_in(1'b1, 32'h28);
        tick;
        chk("bp_still_full", 160'(in_ready), 160'(0));
        chk("bp_still_20", 160'(out_pc4), 160'(32'h20));
        out_ready = 1'b1;
        tick;
        chk("bp_out_24", 160'(out_pc4), 160'(32'h24));
        chk("bp_in_ready_back", 160'(in_ready), 160'(1));
        tick;
        chk("bp_out_28", 160'(out_pc4), 160'(32'h28));
        set_in(1'b0, 32'h0);
        tick;
        chk("bp_empty", 160'(out_valid), 160'(0));

        // Flush with main and skid both full, input presented in the same cycle.
        out_ready = 1'b0;
        set_in(1'b1, 32'h30);
        tick;
        set_in(1'b1, 32'h34);
        tick;
        chk("fl_full", 160'(in_ready), 160'(0));
        flush = 1'b1;
        set_in(1'b1, 32'h38);
        tick;
        flush = 1'b0;
        set_in(1'b0, 32'h0);
        chk("fl_out_valid", 160'(out_valid), 160'(0));
        chk("fl_ctrl_gated", 160'({out_wb, out_m, out_ex}), 160'(0));
        chk("fl_in_ready", 160'(in_ready), 160'(1));
        chk("fl_data_kept", 160'(out_pc4), 160'(32'h30));

        // Flush while the stage is ready drops the same-cycle input.
        set_in(1'b1, 32'h3C);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        set_in(1'b0, 32'h0);
        chk("fl_drop_input", 160'(out_valid), 160'(0));
        out_ready = 1'b1;
        repeat (2) tick;
        chk("fl_no_leak", 160'(out_valid), 160'(0));

        // Asynchronous reset while stalled with both entries full.
        out_ready = 1'b0;
        set_in(1'b1, 32'h40);
        tick;
        set_in(1'b1, 32'h44);
        tick;
        set_in(1'b0, 32'h0);
        chk("ar_full", 160'(in_ready), 160'(0));
        chk("ar_pre_cnt", 160'(bubble_cnt), 160'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 160'(out_valid), 160'(0));
        chk("ar_bubble_cnt", 160'(bubble_cnt), 160'(0));
        chk("ar_in_ready", 160'(in_ready), 160'(1));
        chk("ar_out_pc4", 160'(out_pc4), 160'(0));
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Bubble counter saturates at 3 and keeps counting through a flush.
        for (int i = 0; i < 5; i++) begin
            flush = (i == 2);
            tick;
            flush = 1'b0;
            chk("bubble_cnt", 160'(bubble_cnt), 160'(cnt_v[i]));
        end

        tick;
        chk("sb_all_drained", 160'(exp_q.size()), 160'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
